// File: rtl/pwm_capture.sv
// Purpose: recovers the N-bit duty value of an asynchronous PWM line, one sample per PWM period.
// Latency: pwm_in_i rising edge to valid_o is 3 clk (4 clk when PWM_CAPTURE_DEGLITCH_EN is defined).
// Backpressure: none; valid_o is a one-cycle strobe and the consumer must take it when it fires.
//
// Ports:
//   clk_i         system clock, all logic on the rising edge
//   rst_ni        synchronous active-low reset
//   pwm_in_i      asynchronous PWM line
//   duty_o        last recovered duty (high cycles per frame, clipped to 2^N-1)
//   valid_o       one-cycle strobe: duty_o, period_err_o and stuck_o were updated
//   period_err_o  last completed frame length was not 2^N cycles
//   stuck_o       last timeout happened with the line high
// Build option: PWM_CAPTURE_DEGLITCH_EN inserts a 3-sample majority filter after the synchronizer.
module pwm_capture #(
    parameter int N = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         pwm_in_i,
    output logic [N-1:0] duty_o,
    output logic         valid_o,
    output logic         period_err_o,
    output logic         stuck_o
);
    localparam int PW = N + 2;
    localparam int HW = N + 1;
    localparam logic [PW-1:0] FRAME_LEN   = PW'(2**N);
    localparam logic [PW-1:0] TIMEOUT_LEN = PW'(2**N + 2);
    localparam logic [HW-1:0] HIGH_SAT    = HW'(2**N);
    localparam logic [N-1:0]  DUTY_MAX    = '1;

    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          level, level_prev_q;
    logic          rise, timeout;
    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic [HW-1:0] high_cnt_q, high_cnt_d;
    logic [N-1:0]  duty_q, duty_d;
    logic          valid_q, valid_d;
    logic          period_err_q, period_err_d;
    logic          stuck_q, stuck_d;

`ifdef PWM_CAPTURE_DEGLITCH_EN
    // Two older samples of the synced line; the majority of three rejects
    // single-cycle pulses and dropouts and delays both edges by one cycle.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    assign level = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign level = sync2_q;
`endif

    assign rise    = level & ~level_prev_q;
    assign timeout = (period_cnt_q == TIMEOUT_LEN);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
            state_q      <= IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            period_err_q <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            sync1_q      <= pwm_in_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level;
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            period_err_q <= period_err_d;
            stuck_q      <= stuck_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q + PW'(1);
        high_cnt_d   = high_cnt_q;
        duty_d       = duty_q;
        valid_d      = 1'b0;
        period_err_d = period_err_q;
        stuck_d      = stuck_q;

        if (level && (high_cnt_q != HIGH_SAT)) begin
            high_cnt_d = high_cnt_q + HW'(1);
        end

        // The rise cycle is cycle 1 of the new frame, so at the next rise
        // period_cnt_q holds the full frame length and high_cnt_q its high count.
        if (rise) begin
            period_cnt_d = PW'(1);
            high_cnt_d   = HW'(1);
            state_d      = ARMED;
            if (state_q == ARMED) begin
                valid_d      = 1'b1;
                duty_d       = (high_cnt_q == HIGH_SAT) ? DUTY_MAX : high_cnt_q[N-1:0];
                period_err_d = (period_cnt_q != FRAME_LEN);
                stuck_d      = 1'b0;
            end
        end else if (timeout) begin
            period_cnt_d = PW'(1);
            high_cnt_d   = '0;
            state_d      = IDLE;
            valid_d      = 1'b1;
            duty_d       = level ? DUTY_MAX : '0;
            period_err_d = 1'b0;
            stuck_d      = level;
        end
    end

    assign duty_o       = duty_q;
    assign valid_o      = valid_q;
    assign period_err_o = period_err_q;
    assign stuck_o      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Purpose: directed self-checking bench for pwm_capture (N=6).
// Latency: samples are expected LAT cycles after the driven PWM rising edge.
// Backpressure: not applicable; every valid strobe is logged with its cycle stamp.
module tb_pwm_capture;
    localparam int N = 6;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int LAT = 4;
    localparam int DLO = 2;
    localparam int DHI = 62;
`else
    localparam int LAT = 3;
    localparam int DLO = 1;
    localparam int DHI = 63;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pwm_in = 1'b0;
    logic [N-1:0] duty_o;
    logic         valid_o;
    logic         period_err_o;
    logic         stuck_o;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int           t;
        logic [N-1:0] duty;
        logic         err;
        logic         stuck;
    } samp_t;

    typedef struct {
        int period;
        int high;
        int frames;
        int duty;
        int err;
    } vec_t;

    samp_t obs[$];
    samp_t exp_q[$];

    pwm_capture #(.N(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pwm_in_i    (pwm_in),
        .duty_o      (duty_o),
        .valid_o     (valid_o),
        .period_err_o(period_err_o),
        .stuck_o     (stuck_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (valid_o) obs.push_back('{t: cyc, duty: duty_o, err: period_err_o, stuck: stuck_o});
    end

    // Outputs may only move in a strobe cycle (or under reset).
    logic         rst_at_edge = 1'b0;
    logic [N-1:0] prev_duty = '0;
    logic         prev_err = 1'b0;
    logic         prev_stuck = 1'b0;
    always @(posedge clk) rst_at_edge <= rst_n;
    always @(negedge clk) begin
        if (rst_at_edge && !valid_o) begin
            total++;
            if (duty_o != prev_duty || period_err_o != prev_err || stuck_o != prev_stuck) begin
                bad++;
                $display("FAIL hold cyc=%0d: got duty=%0d err=%0b stuck=%0b, held duty=%0d err=%0b stuck=%0b",
                         cyc, duty_o, period_err_o, stuck_o, prev_duty, prev_err, prev_stuck);
            end
        end
        prev_duty  = duty_o;
        prev_err   = period_err_o;
        prev_stuck = stuck_o;
    end

    task automatic cmp(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic add_exp(input int tt, input int d, input int e, input int s);
        samp_t x;
        x.t     = tt;
        x.duty  = d[N-1:0];
        x.err   = e[0];
        x.stuck = s[0];
        exp_q.push_back(x);
    endtask

    // Compare logged strobes with stamps in [t_lo, t_hi] against exp_q, in order.
    task automatic check_window(input string name, input int t_lo, input int t_hi);
        samp_t got[$];
        while (cyc <= t_hi + 1) @(negedge clk);
        foreach (obs[i]) begin
            if (obs[i].t >= t_lo && obs[i].t <= t_hi) got.push_back(obs[i]);
        end
        cmp({name, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size()) begin
                bad++;
                $display("FAIL %s[%0d]: missing, want t=%0d duty=%0d err=%0b stuck=%0b",
                         name, i, exp_q[i].t, exp_q[i].duty, exp_q[i].err, exp_q[i].stuck);
            end else if (got[i].t != exp_q[i].t || got[i].duty != exp_q[i].duty ||
                         got[i].err != exp_q[i].err || got[i].stuck != exp_q[i].stuck) begin
                bad++;
                $display("FAIL %s[%0d]: got t=%0d duty=%0d err=%0b stuck=%0b, want t=%0d duty=%0d err=%0b stuck=%0b",
                         name, i, got[i].t, got[i].duty, got[i].err, got[i].stuck,
                         exp_q[i].t, exp_q[i].duty, exp_q[i].err, exp_q[i].stuck);
            end
        end
        exp_q.delete();
    endtask

    task automatic drive_frames(input int period, input int high, input int frames, output int t0);
        t0 = 0;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < period; i++) begin
                @(negedge clk);
                if (f == 0 && i == 0) t0 = cyc;
                pwm_in = (i < high);
            end
        end
    endtask

    task automatic do_reset(output int r);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
    endtask

    initial begin
        vec_t vecs[9];
        int   r, t0, t1, t2, h0, t_rst;

        vecs[0] = '{64, 20,  4, 20,  0};
        vecs[1] = '{64, DLO, 3, DLO, 0};
        vecs[2] = '{64, 32,  3, 32,  0};
        vecs[3] = '{64, DHI, 3, DHI, 0};
        vecs[4] = '{60, 20,  3, 20,  1};
        vecs[5] = '{64, 20,  3, 20,  0};
        vecs[6] = '{65, 20,  3, 20,  1};
        vecs[7] = '{66, 64,  3, 63,  1};
        vecs[8] = '{64, 20,  2, 20,  0};

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        cmp("reset duty", int'(duty_o), 0);
        cmp("reset valid", int'(valid_o), 0);
        cmp("reset period_err", int'(period_err_o), 0);
        cmp("reset stuck", int'(stuck_o), 0);
        rst_n = 1'b1;

        // Continuous PWM; each vector's first rise closes the previous vector's last frame.
        for (int v = 0; v < 9; v++) begin
            drive_frames(vecs[v].period, vecs[v].high, vecs[v].frames, t0);
            for (int k = 1; k < vecs[v].frames; k++) begin
                add_exp(t0 + k * vecs[v].period + LAT, vecs[v].duty, vecs[v].err, 0);
            end
            check_window($sformatf("vec%0d", v), (v == 0) ? t0 : t0 + LAT + 1,
                         t0 + (vecs[v].frames - 1) * vecs[v].period + LAT);
        end

        // One-cycle reset in the low phase of a frame.
        t_rst = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 41) begin
                t_rst = cyc;
                cmp("midrst duty", int'(duty_o), 0);
                cmp("midrst valid", int'(valid_o), 0);
                cmp("midrst period_err", int'(period_err_o), 0);
                cmp("midrst stuck", int'(stuck_o), 0);
            end
            pwm_in = (i < 20);
            rst_n  = (i != 40);
        end
        drive_frames(64, 20, 3, t0);
        add_exp(t0 + 64 + LAT, 20, 0, 0);
        add_exp(t0 + 128 + LAT, 20, 0, 0);
        check_window("after_rst", t_rst, t0 + 128 + LAT);

        // Single-cycle dropout inside the high phase.
        t1 = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) t1 = cyc;
            pwm_in = (i < 20) && (i != 10);
        end
        drive_frames(64, 20, 2, t2);
`ifdef PWM_CAPTURE_DEGLITCH_EN
        add_exp(t2 + LAT, 20, 0, 0);
`else
        add_exp(t1 + 11 + LAT, 10, 1, 0);
        add_exp(t2 + LAT, 9, 1, 0);
`endif
        add_exp(t2 + 64 + LAT, 20, 0, 0);
        check_window("glitch", t1 + LAT + 1, t2 + 64 + LAT);

        // Line held low after reset: timeout samples every 66 cycles.
        do_reset(r);
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            pwm_in = 1'b0;
        end
        add_exp(r + 67, 0, 0, 0);
        add_exp(r + 133, 0, 0, 0);
        add_exp(r + 199, 0, 0, 0);
        check_window("stuck_low", r, r + 205);

        // Line held high, then normal PWM resumes.
        h0 = 0;
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            if (i == 0) h0 = cyc;
            pwm_in = (i < 200);
        end
        drive_frames(64, 20, 3, t0);
        for (int k = 0; k < 3; k++) add_exp(h0 + LAT + 66 + 66 * k, 63, 0, 1);
        add_exp(t0 + 64 + LAT, 20, 0, 0);
        add_exp(t0 + 128 + LAT, 20, 0, 0);
        check_window("stuck_high", h0 + LAT, t0 + 128 + LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the `pwm` generator. It samples an asynchronous single-bit PWM line and recovers the N-bit duty value driven by the transmitter, one sample per PWM period. It presents the value with a one-cycle `valid` strobe, a period-error flag and a stuck-line flag. It is used on the bench and in loopback builds to check filter outputs after they pass through `pwm` (e.g. `low_pass_pwm`, `high_pass_pwm`).

## Interface
- `N`, default 6: duty resolution in bits; nominal PWM period = 2^N clk cycles.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `pwm_in`  input  1  asynchronous PWM line.
- `duty`  output  N  last recovered duty (count of high cycles per period).
- `valid`  output  1  one-cycle strobe: `duty`, `period_err` and `stuck` were updated this cycle.
- `period_err`  output  1  last completed frame length ≠ 2^N cycles.
- `stuck`  output  1  last timeout happened with the line high.

## Operation
- Input path: 2-flop synchronizer, then a registered copy for edge detect. A rise is when `sync` is 1 and `sync_d` is 0.
- Counters:
  - `period_cnt` (N+2 bits) counts cycles since the last rise or timeout.
  - `high_cnt` (N+1 bits, saturating at 2^N) counts synced-high cycles in the current frame, including the rise cycle.
- FSM states: IDLE, ARMED.
  - IDLE: wait for a rise. On a rise, clear counters (frame starts with `high_cnt` = 1), go to ARMED, no `valid`.
  - ARMED, on rise:
    - Emit a sample: `duty` = `high_cnt` clipped to 2^N−1; `period_err` = (frame length ≠ 2^N); `stuck` = 0.
    - Restart counters; stay in ARMED.
  - Timeout (any state): `period_cnt` reaches 2^N+2 with no rise.
    - Emit a sample: `duty` = 0 and `stuck` = 0 if synced level is low; `duty` = 2^N−1 and `stuck` = 1 if high; `period_err` = 0.
    - Restart `period_cnt`, go to IDLE.
    - A constant line therefore yields one sample every 2^N+2 cycles.
- A rise and a timeout in the same cycle: the rise wins.
- Frame with `high_cnt` saturated (line high > 2^N−1 cycles but rising again): `duty` = 2^N−1 and `period_err` = 1.
- Reset (`rst` = 0): state IDLE, counters, synchronizer and all outputs cleared. Reset mid-frame discards the partial frame; the first rise after release only arms.

## Timing
- Reset values: `duty` = 0, `valid` = 0, `period_err` = 0, `stuck` = 0.
- `pwm_in` edge to rise detection: 2 clk, rising 3 with deglitch enabled (see Configuration).
- Rise detection to `valid` high: 1 clk. `valid` is exactly 1 cycle wide.
- `duty`, `period_err` and `stuck` change only in the cycle `valid` is asserted, and hold otherwise.
- First `valid` after reset or a timeout: at the second detected rise (one full frame observed).
- Steady-state throughput: one sample per input period; consecutive `valid` pulses are 2^N cycles apart for a conforming input.

## Configuration
- `PWM_CAPTURE_DEGLITCH_EN`
  - Defined: a 3-sample majority filter follows the synchronizer. Single-cycle pulses or dropouts are rejected and add +1 cycle detection latency. `duty` for clean input is unchanged, since both edges are delayed equally.
  - Undefined: the filter is absent and the synced level feeds edge detect directly. A 1-cycle glitch produces a short frame with `period_err` = 1.

## Test plan
- N=6, period 64, high for 20 cycles, repeated -> first `valid` at 2nd rise +3 clk; then `valid` every 64 cycles with `duty` = 20, `period_err` = 0, `stuck` = 0.
- Duty sweep: `pwm_in` driven by the `pwm` instance with values 1, 32, 63 -> `duty` follows with a one-frame lag; 63 gives `duty` = 63 with no error.
- Line held low after reset -> `valid` every 66 cycles with `duty` = 0, `stuck` = 0.
- Line held high -> `valid` every 66 cycles with `duty` = 63, `stuck` = 1. Then resume 20/64 PWM -> first good sample at the 2nd rise.
- Period 60 (high 20) -> `duty` = 20, `period_err` = 1 each frame. Period 64 (high 20) restored -> `period_err` returns to 0.
- `rst` = 0 for 1 cycle mid-frame -> all outputs 0 next cycle, no `valid` until the 2nd rise after release. With `PWM_CAPTURE_DEGLITCH_EN`, a 1-cycle low glitch inside the high phase -> no extra `valid`, `duty` unchanged.
